// File: rtl/modrm_encode.sv
// modrm_encode
//   Writes an 8086 ModRM byte, then 0, 1 or 2 little-endian displacement
//   bytes, into a byte FIFO write port. It chooses the shortest legal form:
//   mod 00 first, then disp8, then disp16. It is the writer-side partner of
//   the ModRM decoder that pops the same byte stream.
//
// Parameters
//   FORCE_DISP16  1: never emit disp8. Any non-zero or BP-only displacement
//                 uses mod 10.
//
// Ports
//   clk, reset     clock and synchronous active-high reset
//   start          one-cycle request; operands are captured when it is
//                  accepted (IDLE only)
//   regnum         ModRM reg field
//   rm_is_reg      1: register operand (mod 11, rm = rm_regnum)
//   rm_regnum      rm field for register operands
//   base_sel       0 none, 1 BX, 2 BP, 3 none
//   index_sel      0 none, 1 SI, 2 DI, 3 none
//   displacement   displacement, or the direct address when base and index
//                  are both none
//   busy           high in every non-IDLE state
//   complete       high in the cycle the final byte is pushed
//   num_bytes      length of the current encoding (1..3), held until the
//                  next accepted start
//   fifo_wr_en     push strobe
//   fifo_wr_data   byte being pushed
//   fifo_full      the FIFO cannot accept a push this cycle
//   state          debug view of the FSM state
//
// Handshake: a byte moves in any cycle where fifo_wr_en is high, and
// fifo_wr_en = busy & ~fifo_full. The FSM advances only on such a push.
// While fifo_full is high, the state and fifo_wr_data are held.
module modrm_encode #(
  parameter bit FORCE_DISP16 = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  regnum,
  input  logic        rm_is_reg,
  input  logic [2:0]  rm_regnum,
  input  logic [1:0]  base_sel,
  input  logic [1:0]  index_sel,
  input  logic [15:0] displacement,
  output logic        busy,
  output logic        complete,
  output logic [1:0]  num_bytes,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MODRM   = 2'd1;
  localparam logic [1:0] DISP_LO = 2'd2;
  localparam logic [1:0] DISP_HI = 2'd3;

  logic [7:0]  modrm_q;
  logic [15:0] disp_q;

  // Encoding of the operands presented on the inputs this cycle.
  logic        has_bx, has_bp, has_si, has_di;
  logic        bp_only, direct, disp_zero, disp_fits8;
  logic [1:0]  enc_mod;
  logic [2:0]  enc_rm;
  logic [1:0]  enc_len;

  always_comb begin
    has_bx     = (base_sel == 2'd1);
    has_bp     = (base_sel == 2'd2);
    has_si     = (index_sel == 2'd1);
    has_di     = (index_sel == 2'd2);
    bp_only    = has_bp & ~has_si & ~has_di;
    direct     = ~has_bx & ~has_bp & ~has_si & ~has_di;
    disp_zero  = (displacement == 16'h0000);
    // disp8 is sign-extended by the decoder, so bits 15..7 must agree.
    disp_fits8 = (&displacement[15:7]) | ~(|displacement[15:7]);

    enc_rm = 3'b110;
    case ({has_bx, has_bp, has_si, has_di})
      4'b1010: enc_rm = 3'b000;
      4'b1001: enc_rm = 3'b001;
      4'b0110: enc_rm = 3'b010;
      4'b0101: enc_rm = 3'b011;
      4'b0010: enc_rm = 3'b100;
      4'b0001: enc_rm = 3'b101;
      4'b0100: enc_rm = 3'b110;
      4'b1000: enc_rm = 3'b111;
      default: enc_rm = 3'b110;  // direct address
    endcase

    enc_mod = 2'b10;
    enc_len = 2'd3;
    if (rm_is_reg) begin
      enc_mod = 2'b11;
      enc_rm  = rm_regnum;
      enc_len = 2'd1;
    end else if (direct) begin
      enc_mod = 2'b00;
      enc_len = 2'd3;
    end else if (disp_zero && !bp_only) begin
      enc_mod = 2'b00;
      enc_len = 2'd1;
    end else if (!FORCE_DISP16 && disp_fits8) begin
      // This also covers BP-only with zero displacement (mod 01, disp8 0).
      enc_mod = 2'b01;
      enc_len = 2'd2;
    end else begin
      enc_mod = 2'b10;
      enc_len = 2'd3;
    end
  end

  assign busy       = (state != IDLE);
  assign fifo_wr_en = busy & ~fifo_full;

  logic last_byte;
  always_comb begin
    last_byte    = 1'b0;
    fifo_wr_data = 8'h00;
    case (state)
      MODRM: begin
        fifo_wr_data = modrm_q;
        last_byte    = (num_bytes == 2'd1);
      end
      DISP_LO: begin
        fifo_wr_data = disp_q[7:0];
        last_byte    = (num_bytes == 2'd2);
      end
      DISP_HI: begin
        fifo_wr_data = disp_q[15:8];
        last_byte    = 1'b1;
      end
      default: begin
        fifo_wr_data = 8'h00;
        last_byte    = 1'b0;
      end
    endcase
  end

  assign complete = fifo_wr_en & last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      num_bytes <= 2'd0;
      modrm_q   <= 8'h00;
      disp_q    <= 16'h0000;
    end else if (state == IDLE) begin
      if (start) begin
        state     <= MODRM;
        num_bytes <= enc_len;
        modrm_q   <= {enc_mod, regnum, enc_rm};
        disp_q    <= displacement;
      end
    end else if (fifo_wr_en) begin
      if (last_byte) begin
        state <= IDLE;
      end else if (state == MODRM) begin
        state <= DISP_LO;
      end else begin
        state <= DISP_HI;
      end
    end
  end

endmodule
